// File: rtl/wb_regfile_pkg.sv
// Shared constants and read-port selection type for the write-back register file.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
// Optional feature macro consumed by users of this package: WB_REGFILE_BYPASS_EN.
package wb_regfile_pkg;

    localparam int XLEN       = 64;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    // Where a read port takes its data from in the current cycle.
    typedef enum logic [1:0] {
        RD_SEL_ZERO   = 2'd0,  // x0, reset, or out-of-range address
        RD_SEL_REG    = 2'd1,  // stored register value
        RD_SEL_BYPASS = 2'd2   // write-through of the value being written back
    } rd_sel_t;

    // Pick the data source for one read port. The bypass is never taken for
    // x0 and never while reset is high, so reset always reads as zero.
    function automatic rd_sel_t rd_sel(
        input logic                  rst,
        input logic                  bypass_en,
        input logic                  reg_write,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  rs_in_range
    );
        rd_sel_t sel;
        sel = RD_SEL_REG;
        if (rst || (rs == '0) || !rs_in_range) begin
            sel = RD_SEL_ZERO;
        end else if (bypass_en && reg_write && (rd != '0) && (rs == rd)) begin
            sel = RD_SEL_BYPASS;
        end
        return sel;
    endfunction

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// Write-back data select: load value or ALU result, chosen by MemToReg.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the mux is always ready.
module wb_mux #(
    parameter int XLEN = wb_regfile_pkg::XLEN
) (
    input  logic            mem_to_reg,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] read_data,
    output logic [XLEN-1:0] wb_data
);

    // Select the value that the MEM/WB stage retires into the register file.
    always_comb begin
        wb_data = alu_result;
        if (mem_to_reg) begin
            wb_data = read_data;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Integer register file with two combinational read ports and one write-back port.
// Latency: reads zero cycles; a write lands on the rising edge (optional same-cycle
// write-through when WB_REGFILE_BYPASS_EN is defined). Backpressure: none, always ready.
module wb_regfile #(
    parameter int XLEN  = wb_regfile_pkg::XLEN,
    parameter int NREGS = wb_regfile_pkg::NREGS
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  MEMWB_RegWrite,
    input  logic                                  MEMWB_MemToReg,
    input  logic [XLEN-1:0]                       MEMWB_ALU_Result,
    input  logic [XLEN-1:0]                       MEMWB_Read_Data,
    input  logic [wb_regfile_pkg::REG_ADDR_W-1:0] MEMWB_Instruction_11_7,
    input  logic [wb_regfile_pkg::REG_ADDR_W-1:0] rs1,
    input  logic [wb_regfile_pkg::REG_ADDR_W-1:0] rs2,
    output logic [XLEN-1:0]                       ReadData1,
    output logic [XLEN-1:0]                       ReadData2,
    output logic [XLEN-1:0]                       WB_Data
);

    import wb_regfile_pkg::*;

`ifdef WB_REGFILE_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en;
    logic            rs1_in_range;
    logic            rs2_in_range;
    rd_sel_t         sel1;
    rd_sel_t         sel2;

    // The write-back value is shared with the forwarding unit, so it is never
    // gated by reset.
    wb_mux #(
        .XLEN(XLEN)
    ) u_wb_mux (
        .mem_to_reg (MEMWB_MemToReg),
        .alu_result (MEMWB_ALU_Result),
        .read_data  (MEMWB_Read_Data),
        .wb_data    (WB_Data)
    );

    assign wr_en        = MEMWB_RegWrite && (MEMWB_Instruction_11_7 != '0)
                          && (int'(MEMWB_Instruction_11_7) < NREGS);
    assign rs1_in_range = int'(rs1) < NREGS;
    assign rs2_in_range = int'(rs2) < NREGS;

    // Storage: cleared asynchronously; x0 is never written so it stays zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[MEMWB_Instruction_11_7] <= WB_Data;
        end
    end

    // Decide each read port's source independently so rs1==rs2 yields identical data.
    always_comb begin
        sel1 = rd_sel(reset, BYPASS_EN, MEMWB_RegWrite, MEMWB_Instruction_11_7,
                      rs1, rs1_in_range);
        sel2 = rd_sel(reset, BYPASS_EN, MEMWB_RegWrite, MEMWB_Instruction_11_7,
                      rs2, rs2_in_range);
    end

    // Read port 1 data mux.
    always_comb begin
        ReadData1 = '0;
        case (sel1)
            RD_SEL_REG:    ReadData1 = regs[rs1];
            RD_SEL_BYPASS: ReadData1 = WB_Data;
            default:       ReadData1 = '0;
        endcase
    end

    // Read port 2 data mux.
    always_comb begin
        ReadData2 = '0;
        case (sel2)
            RD_SEL_REG:    ReadData2 = regs[rs2];
            RD_SEL_BYPASS: ReadData2 = WB_Data;
            default:       ReadData2 = '0;
        endcase
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table plus hand sequences for reset and hazards.
// Latency: inputs driven on the falling edge, outputs sampled 1 ns later.
// Backpressure: n/a.
module tb_wb_regfile;

    logic        clock;
    logic        reset;
    logic        MEMWB_RegWrite;
    logic        MEMWB_MemToReg;
    logic [63:0] MEMWB_ALU_Result;
    logic [63:0] MEMWB_Read_Data;
    logic [4:0]  MEMWB_Instruction_11_7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic [63:0] WB_Data;

    int errors = 0;
    int checks = 0;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        rw;
        logic        mtr;
        logic [63:0] alu;
        logic [63:0] rdat;
        logic [4:0]  rd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [63:0] e_wb;
        logic [63:0] e_r1;
        logic [63:0] e_r2;
    } vec_t;

    vec_t tv [10];

    wb_regfile dut (
        .clock                  (clock),
        .reset                  (reset),
        .MEMWB_RegWrite         (MEMWB_RegWrite),
        .MEMWB_MemToReg         (MEMWB_MemToReg),
        .MEMWB_ALU_Result       (MEMWB_ALU_Result),
        .MEMWB_Read_Data        (MEMWB_Read_Data),
        .MEMWB_Instruction_11_7 (MEMWB_Instruction_11_7),
        .rs1                    (rs1),
        .rs2                    (rs2),
        .ReadData1              (ReadData1),
        .ReadData2              (ReadData2),
        .WB_Data                (WB_Data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic mtr, input logic [63:0] alu,
                         input logic [63:0] rdat, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2);
        MEMWB_RegWrite         = rw;
        MEMWB_MemToReg         = mtr;
        MEMWB_ALU_Result       = alu;
        MEMWB_Read_Data        = rdat;
        MEMWB_Instruction_11_7 = rd;
        rs1                    = r1;
        rs2                    = r2;
    endtask

    initial begin
        // Expected read values are the contents before the edge that ends the vector.
        tv[0] = '{1'b0, 1'b0, 64'h1234, 64'h0, 5'd5, 5'd5, 5'd0, 64'h1234, 64'h0, 64'h0};
        tv[1] = '{1'b1, 1'b0, 64'h1234, 64'h0, 5'd5, 5'd1, 5'd2, 64'h1234, 64'h0, 64'h0};
        tv[2] = '{1'b0, 1'b1, 64'h1234, 64'h99, 5'd5, 5'd5, 5'd5, 64'h99, 64'h1234, 64'h1234};
        tv[3] = '{1'b1, 1'b1, 64'h77, 64'hDEADBEEF_00000001, 5'd7, 5'd5, 5'd0,
                  64'hDEADBEEF_00000001, 64'h1234, 64'h0};
        tv[4] = '{1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 5'd0, 5'd7, 5'd5,
                  64'hFFFFFFFF_FFFFFFFF, 64'hDEADBEEF_00000001, 64'h1234};
        tv[5] = '{1'b0, 1'b0, 64'h5555, 64'h0, 5'd0, 5'd0, 5'd7,
                  64'h5555, 64'h0, 64'hDEADBEEF_00000001};
        tv[6] = '{1'b1, 1'b0, 64'h3, 64'h0, 5'd31, 5'd5, 5'd7,
                  64'h3, 64'h1234, 64'hDEADBEEF_00000001};
        tv[7] = '{1'b0, 1'b0, 64'h0, 64'h0, 5'd31, 5'd31, 5'd31, 64'h0, 64'h3, 64'h3};
        tv[8] = '{1'b1, 1'b1, 64'h0, 64'h0BAD, 5'd5, 5'd7, 5'd31,
                  64'h0BAD, 64'hDEADBEEF_00000001, 64'h3};
        tv[9] = '{1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd5, 5'd31, 64'h0, 64'h0BAD, 64'h3};

        // Reset state at time zero.
        reset = 1'b1;
        drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd1, 5'd2);
        #1;
        chk("reset_rd1", ReadData1, 64'h0);
        chk("reset_rd2", ReadData2, 64'h0);

        // Preload every register, then confirm a couple landed.
        @(negedge clock);
        reset = 1'b0;
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 1'b0, 64'h1000 + 64'(i), 64'h0, 5'(i), 5'd0, 5'd0);
            @(negedge clock);
        end
        drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd31, 5'd1);
        #1;
        chk("preload_x31", ReadData1, 64'h101F);
        chk("preload_x1", ReadData2, 64'h1001);

        // Asynchronous reset with preloaded registers and a pending write: all reads
        // zero at once, WB_Data still follows the mux, and no write lands while held.
        drive(1'b1, 1'b0, 64'hFFFF, 64'h0, 5'd31, 5'd31, 5'd31);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_x31", ReadData1, 64'h0);
        chk("rst_wb_data", WB_Data, 64'hFFFF);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            chk($sformatf("rst_rd1_x%0d", i), ReadData1, 64'h0);
            chk($sformatf("rst_rd2_x%0d", 31 - i), ReadData2, 64'h0);
        end
        @(negedge clock);
        drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd31, 5'd0);
        reset = 1'b0;
        #1;
        chk("rst_no_write_x31", ReadData1, 64'h0);

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            drive(tv[i].rw, tv[i].mtr, tv[i].alu, tv[i].rdat, tv[i].rd, tv[i].r1, tv[i].r2);
            #1;
            chk($sformatf("vec%0d_wb", i), WB_Data, tv[i].e_wb);
            chk($sformatf("vec%0d_rd1", i), ReadData1, tv[i].e_r1);
            chk($sformatf("vec%0d_rd2", i), ReadData2, tv[i].e_r2);
        end

        // Same-cycle write and read of x3 (x3 holds 0 after the reset).
        @(negedge clock);
        drive(1'b1, 1'b0, 64'hAA, 64'h0, 5'd3, 5'd3, 5'd3);
        #1;
        chk("hazard_x3_rd1", ReadData1, BYP ? 64'hAA : 64'h0);
        chk("hazard_x3_rd2", ReadData2, BYP ? 64'hAA : 64'h0);
        @(negedge clock);
        drive(1'b1, 1'b0, 64'hBB, 64'h0, 5'd0, 5'd0, 5'd3);
        #1;
        chk("hazard_x0_rd1", ReadData1, 64'h0);
        chk("hazard_x3_after", ReadData2, 64'hAA);

        // Reset pulse between edges after x9=0x55; the write at the next edge lands.
        @(negedge clock);
        drive(1'b1, 1'b0, 64'h55, 64'h0, 5'd9, 5'd0, 5'd0);
        @(negedge clock);
        drive(1'b1, 1'b0, 64'h66, 64'h0, 5'd9, 5'd9, 5'd3);
        #1;
        chk("pulse_pre_x9", ReadData1, BYP ? 64'h66 : 64'h55);
        reset = 1'b1;
        #1;
        chk("pulse_x9_zero", ReadData1, 64'h0);
        chk("pulse_x3_zero", ReadData2, 64'h0);
        chk("pulse_wb_data", WB_Data, 64'h66);
        reset = 1'b0;
        #1;
        chk("pulse_rel_x9", ReadData1, BYP ? 64'h66 : 64'h0);
        @(negedge clock);
        drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd9, 5'd3);
        #1;
        chk("pulse_after_x9", ReadData1, 64'h66);
        chk("pulse_after_x3", ReadData2, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have one clock, and reset SHALL be asynchronous and active-high; the ports SHALL be named clock and reset.
REQ-002 Parameter XLEN, default 64: data width of every register and every data port.
REQ-003 Parameter NREGS, default 32: number of architectural registers, addressed by 5 bits.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 MEMWB_RegWrite  input  1  write-back enable from the MEM/WB pipeline register.
REQ-007 MEMWB_MemToReg  input  1  write-data select: 1 = Read_Data, 0 = ALU_Result.
REQ-008 MEMWB_ALU_Result  input  XLEN  ALU result from the MEM/WB register.
REQ-009 MEMWB_Read_Data  input  XLEN  data-memory load value from the MEM/WB register.
REQ-010 MEMWB_Instruction_11_7  input  5  destination register (rd).
REQ-011 rs1  input  5  read port 1 address.
REQ-012 rs2  input  5  read port 2 address.
REQ-013 ReadData1  output  XLEN  read port 1 data.
REQ-014 ReadData2  output  XLEN  read port 2 data.
REQ-015 WB_Data  output  XLEN  selected write-back value, for the forwarding unit.

Function
REQ-016 WB_Data SHALL equal MEMWB_Read_Data when MEMWB_MemToReg=1 and MEMWB_ALU_Result otherwise, combinationally.
REQ-017 On the rising clock edge, when MEMWB_RegWrite=1 and rd!=0, register[rd] SHALL be loaded with WB_Data.
REQ-018 When MEMWB_RegWrite=0, no register SHALL change.
REQ-019 Register x0 SHALL always read as 0; writes to rd=0 SHALL be discarded.
REQ-020 Reads SHALL be combinational, with zero-cycle latency from rs1/rs2 to ReadData1/ReadData2.
REQ-021 Both read ports SHALL operate independently, and rs1==rs2 SHALL return identical data on both ports.
REQ-022 A write in cycle N SHALL be visible on the read ports no later than cycle N+1.
REQ-023 The same-cycle read of a register being written SHALL follow REQ-030/REQ-031.

Reset
REQ-024 On assertion of reset, all NREGS registers SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-025 While reset is high, ReadData1, ReadData2 and the register contents SHALL be 0, and no write SHALL take effect.
REQ-026 WB_Data SHALL remain the combinational mux output during reset and SHALL NOT be forced.
REQ-027 When reset deasserts, the first write SHALL occur on the first rising edge with reset low.
REQ-028 A reset pulse between clock edges SHALL clear the state, and any write pending at the next edge SHALL proceed normally.

Configuration
REQ-029 The feature SHALL be controlled by the macro WB_REGFILE_BYPASS_EN.
REQ-030 When WB_REGFILE_BYPASS_EN is defined, and MEMWB_RegWrite=1, rd!=0 and rsX==rd, ReadDataX SHALL return WB_Data in the same cycle (write-through, no WB->ID hazard).
REQ-031 When WB_REGFILE_BYPASS_EN is undefined, ReadDataX SHALL return the old register value until the edge, and the hazard is left to the forwarding unit.
REQ-032 The bypass SHALL never apply to rd=0.

Structure
REQ-033 A shared package SHALL hold the constants XLEN=64, NREGS=32 and REG_ADDR_W=5, and the read-port selection typedef.
REQ-034 The write-back select (REQ-016) SHALL be the sub-module wb_mux; the storage and read logic SHALL stay in wb_regfile.
REQ-035 The implementation SHALL be in the range of 120-400 lines of RTL.

Verification
REQ-036 Reset with registers preloaded -> ReadData1 and ReadData2 = 0 for every address before any clock edge.
REQ-037 Write rd=5, ALU_Result=0x1234, MemToReg=0 -> rs1=5 returns 0x1234 on the next cycle; register x5 is unchanged while RegWrite=0.
REQ-038 Write rd=7, Read_Data=0xDEADBEEF_00000001, MemToReg=1 -> WB_Data shows the value immediately, and rs2=7 returns it after the edge.
REQ-039 Write rd=0 with 0xFFFF...F -> rs1=0 still returns 0.
REQ-040 Same-cycle write rd=3=rs1 with value 0xAA -> returns 0xAA in that cycle with the macro defined, and the old value without it.
REQ-041 Reset asserted mid-cycle after a write of x9=0x55 -> x9 reads 0 at once, and the write at the next edge with reset low lands correctly.
